rx_tlp_trigger_pg: RTL and testbench

Parametrised successor of the RX TLP trigger. It watches the committed write pointer of the on-chip RX ring and decides when DMA-write TLPs are emitted towards the current host huge page: full-size TLPs, partial "last" TLPs and page closes. It sits between the RX ring writer and the TLP emitter. Compared with the fixed version, it adds:

- configurable ring, TLP and page geometry;
- a runtime timeout value;
- host-page-availability gating;
- an exported read pointer.

---
 rtl/rx_tlp_trigger_pg.sv | 139 +++++++++++++
 tb/tb_rx_tlp_trigger_pg.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_tlp_trigger_pg.sv
// Decides when full-size, partial "last" and page-close DMA-write TLP requests
// are issued, based on the committed RX ring write pointer and the host page offset.
module rx_tlp_trigger_pg #(
    parameter int AW      = 15,
    parameter int MAX_QW  = 16,
    parameter int PAGE_QW = 262144,
    parameter int HDR_QW  = 16,
    parameter int TW      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [AW-1:0]           commited_wr_address,
    input  logic [TW-1:0]           timeout_value,
    input  logic                    huge_page_available,
    output logic                    trigger_tlp,
    input  logic                    trigger_tlp_ack,
    output logic                    send_last_tlp,
    output logic                    change_huge_page,
    input  logic                    change_huge_page_ack,
    output logic [$clog2(MAX_QW):0] qwords_to_send,
    output logic [AW-1:0]           commited_rd_address
);
    localparam int QW_W  = $clog2(MAX_QW) + 1;
    localparam int OFF_W = $clog2(PAGE_QW) + 1;
    localparam int CW    = ((AW > OFF_W) ? AW : OFF_W) + 1;

    typedef enum logic [2:0] {IDLE, FULL, LAST, CLOSE, SETTLE} state_t;

    state_t           state, state_n;
    logic [AW-1:0]    diff, rd, rd_n;
    logic [OFF_W-1:0] off, off_n, room;
    logic [TW-1:0]    tcnt;
    logic             trig_n, last_n, chg_n;
    logic [QW_W-1:0]  qw_n;
    logic [CW-1:0]    diff_w, room_w;
    logic             dirty, expired;

    assign room    = OFF_W'(PAGE_QW) - off;
    assign diff_w  = CW'(diff);
    assign room_w  = CW'(room);
    assign dirty   = (off != OFF_W'(HDR_QW));
    assign expired = (timeout_value != '0) && (tcnt >= timeout_value);

    assign commited_rd_address = rd;

    always_comb begin
        state_n = state;
        trig_n  = trigger_tlp;
        last_n  = send_last_tlp;
        chg_n   = change_huge_page;
        qw_n    = qwords_to_send;
        rd_n    = rd;
        off_n   = off;
        case (state)
            IDLE: begin
                if (huge_page_available) begin
                    if (diff_w >= CW'(MAX_QW)) begin
                        if (room_w >= CW'(MAX_QW)) begin
                            qw_n    = QW_W'(MAX_QW);
                            trig_n  = 1'b1;
                            state_n = FULL;
                        end else if (room != '0) begin
                            qw_n    = QW_W'(room);
                            last_n  = 1'b1;
                            state_n = LAST;
                        end else begin
                            chg_n   = 1'b1;
                            state_n = CLOSE;
                        end
                    end else if (expired) begin
                        if ((diff != '0) && (room != '0)) begin
                            qw_n    = (diff_w < room_w) ? QW_W'(diff) : QW_W'(room);
                            last_n  = 1'b1;
                            state_n = LAST;
                        end else if (dirty) begin
                            chg_n   = 1'b1;
                            state_n = CLOSE;
                        end
                    end
                end
            end
            FULL: begin
                if (trigger_tlp_ack) begin
                    trig_n  = 1'b0;
                    rd_n    = rd + AW'(MAX_QW);
                    off_n   = off + OFF_W'(MAX_QW);
                    state_n = SETTLE;
                end
            end
            LAST: begin
                if (change_huge_page_ack) begin
                    last_n  = 1'b0;
                    rd_n    = rd + AW'(qwords_to_send);
                    off_n   = OFF_W'(HDR_QW);
                    state_n = SETTLE;
                end
            end
            CLOSE: begin
                if (change_huge_page_ack) begin
                    chg_n   = 1'b0;
                    off_n   = OFF_W'(HDR_QW);
                    state_n = SETTLE;
                end
            end
            SETTLE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // tcnt saturates so a long idle period cannot wrap back below the timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            diff             <= '0;
            rd               <= '0;
            off              <= OFF_W'(HDR_QW);
            tcnt             <= '0;
            trigger_tlp      <= 1'b0;
            send_last_tlp    <= 1'b0;
            change_huge_page <= 1'b0;
            qwords_to_send   <= '0;
        end else begin
            state            <= state_n;
            diff             <= commited_wr_address - rd;
            rd               <= rd_n;
            off              <= off_n;
            trigger_tlp      <= trig_n;
            send_last_tlp    <= last_n;
            change_huge_page <= chg_n;
            qwords_to_send   <= qw_n;
            if (state != IDLE) begin
                tcnt <= '0;
            end else if (tcnt != '1) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rx_tlp_trigger_pg.sv
// Self-checking bench for rx_tlp_trigger_pg: directed vector table, hand-written
// timing sequences and a randomized run against a transaction-level page model.
module tb_rx_tlp_trigger_pg;

    localparam int K_NONE  = 0;
    localparam int K_FULL  = 1;
    localparam int K_LAST  = 2;
    localparam int K_CLOSE = 3;

    // geometry of instance 2, used by the random model
    localparam int M_MAX  = 16;
    localparam int M_PAGE = 64;
    localparam int M_HDR  = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] wr0;
    logic [5:0]  wr1, wr2;
    logic [15:0] tmo  [3];
    logic        hpa  [3];
    logic        tack [3];
    logic        cack [3];
    logic        trig [3];
    logic        last [3];
    logic        chg  [3];
    logic [4:0]  qw   [3];
    logic [14:0] rd0;
    logic [5:0]  rd1, rd2;
    bit          rand_hpa [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_tlp_trigger_pg u0 (
        .clk(clk), .reset_n(reset_n), .commited_wr_address(wr0), .timeout_value(tmo[0]),
        .huge_page_available(hpa[0]), .trigger_tlp(trig[0]), .trigger_tlp_ack(tack[0]),
        .send_last_tlp(last[0]), .change_huge_page(chg[0]), .change_huge_page_ack(cack[0]),
        .qwords_to_send(qw[0]), .commited_rd_address(rd0)
    );

    rx_tlp_trigger_pg #(.AW(6), .PAGE_QW(64), .HDR_QW(16)) u1 (
        .clk(clk), .reset_n(reset_n), .commited_wr_address(wr1), .timeout_value(tmo[1]),
        .huge_page_available(hpa[1]), .trigger_tlp(trig[1]), .trigger_tlp_ack(tack[1]),
        .send_last_tlp(last[1]), .change_huge_page(chg[1]), .change_huge_page_ack(cack[1]),
        .qwords_to_send(qw[1]), .commited_rd_address(rd1)
    );

    rx_tlp_trigger_pg #(.AW(6), .PAGE_QW(M_PAGE), .HDR_QW(M_HDR)) u2 (
        .clk(clk), .reset_n(reset_n), .commited_wr_address(wr2), .timeout_value(tmo[2]),
        .huge_page_available(hpa[2]), .trigger_tlp(trig[2]), .trigger_tlp_ack(tack[2]),
        .send_last_tlp(last[2]), .change_huge_page(chg[2]), .change_huge_page_ack(cack[2]),
        .qwords_to_send(qw[2]), .commited_rd_address(rd2)
    );

    function automatic int cur_kind(input int s);
        if (trig[s]) return K_FULL;
        if (last[s]) return K_LAST;
        if (chg[s])  return K_CLOSE;
        return K_NONE;
    endfunction

    function automatic int get_rd(input int s);
        case (s)
            0:       return int'(rd0);
            1:       return int'(rd1);
            default: return int'(rd2);
        endcase
    endfunction

    task automatic set_wr(input int s, input logic [14:0] v);
        case (s)
            0:       wr0 = v;
            1:       wr1 = v[5:0];
            default: wr2 = v[5:0];
        endcase
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        wr0 = '0; wr1 = '0; wr2 = '0;
        for (int i = 0; i < 3; i++) begin
            tmo[i] = '0; hpa[i] = 1'b1; tack[i] = 1'b0; cack[i] = 1'b0; rand_hpa[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_request(input int s, input int budget, output int kind);
        kind = K_NONE;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            kind = cur_kind(s);
            if (kind != K_NONE) break;
            if (rand_hpa[s]) hpa[s] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic apply_stimulus(input int s, input logic [14:0] wr, input logic [15:0] t);
        set_wr(s, wr);
        tmo[s] = t;
    endtask

    task automatic expect_request(input int s, input int budget, input int ek, input int eq,
                                  input string name);
        int k;
        wait_request(s, budget, k);
        check_output({name, "_kind"}, k, ek);
        if (ek != K_CLOSE && k == ek) check_output({name, "_qw"}, int'(qw[s]), eq);
    endtask

    task automatic ack_request(input int s, input int kind, input int delay, input int exp_rd,
                               input string name);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (rand_hpa[s]) hpa[s] = ($urandom_range(0, 3) != 0);
        end
        if (kind == K_FULL) tack[s] = 1'b1;
        else                cack[s] = 1'b1;
        @(negedge clk);
        tack[s] = 1'b0;
        cack[s] = 1'b0;
        check_output({name, "_drop"}, cur_kind(s), K_NONE);
        check_output({name, "_rd"}, get_rd(s), exp_rd);
    endtask

    // Next request implied by the page rules for the current ring fill and page offset
    function automatic void model_next(input int d, input int off, input int t,
                                       output int kind, output int n);
        int room = M_PAGE - off;
        kind = K_NONE;
        n    = 0;
        if (d >= M_MAX) begin
            if (room >= M_MAX)  begin kind = K_FULL; n = M_MAX; end
            else if (room > 0)  begin kind = K_LAST; n = room; end
            else                      kind = K_CLOSE;
        end else if (t != 0) begin
            if (d > 0 && room > 0)   begin kind = K_LAST; n = (d < room) ? d : room; end
            else if (off != M_HDR)         kind = K_CLOSE;
        end
    endfunction

    // Protocol monitor: one request at a time, held until acked, 2-cycle gap
    logic [2:0] prev_req [3];
    int         gap      [3];
    logic       tack_edge [3];
    logic       cack_edge [3];
    logic [2:0] mon_r;
    logic       mon_ok;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            tack_edge[i] <= tack[i];
            cack_edge[i] <= cack[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            mon_r = {trig[i], last[i], chg[i]};
            if (!reset_n) begin
                prev_req[i] = 3'b000;
                gap[i]      = 100;
            end else begin
                checks++;
                if ($countones(mon_r) > 1) begin
                    errors++;
                    $display("[TB] FAIL onehot_%0d: got %b, expected at most one bit", i, mon_r);
                end
                if (prev_req[i] != 3'b000 && mon_r != prev_req[i]) begin
                    mon_ok = (mon_r == 3'b000) &&
                             ((prev_req[i] == 3'b100) ? tack_edge[i] : cack_edge[i]);
                    checks++;
                    if (!mon_ok) begin
                        errors++;
                        $display("[TB] FAIL hold_%0d: got %b after %b, expected drop only on ack",
                                 i, mon_r, prev_req[i]);
                    end
                end
                if (prev_req[i] == 3'b000 && mon_r != 3'b000) begin
                    checks++;
                    if (gap[i] < 2) begin
                        errors++;
                        $display("[TB] FAIL gap_%0d: got %0d low cycles, expected at least 2", i, gap[i]);
                    end
                end
                gap[i]      = (mon_r == 3'b000) ? gap[i] + 1 : 0;
                prev_req[i] = mon_r;
            end
        end
    end

    typedef struct {
        int          sel;
        logic [14:0] wr;
        logic [15:0] tmo;
        int          kind;
        int          qwn;
        int          rd_after;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int k;
        int m_rd, m_off, m_wr, m_tmo, ek, eq, outst, n;

        vecs[0]  = '{0, 15'h40, 16'd0, K_FULL,  16, 'h10};
        vecs[1]  = '{0, 15'h40, 16'd0, K_FULL,  16, 'h20};
        vecs[2]  = '{0, 15'h40, 16'd0, K_FULL,  16, 'h30};
        vecs[3]  = '{0, 15'h40, 16'd0, K_FULL,  16, 'h40};
        vecs[4]  = '{1, 15'h35, 16'd4, K_FULL,  16, 16};
        vecs[5]  = '{1, 15'h35, 16'd4, K_FULL,  16, 32};
        vecs[6]  = '{1, 15'h35, 16'd4, K_FULL,  16, 48};
        vecs[7]  = '{1, 15'h35, 16'd4, K_CLOSE, 0,  48};
        vecs[8]  = '{1, 15'h35, 16'd4, K_LAST,  5,  53};
        vecs[9]  = '{1, 15'h38, 16'd4, K_LAST,  3,  56};
        vecs[10] = '{1, 15'h08, 16'd4, K_FULL,  16, 8};
        vecs[11] = '{1, 15'h08, 16'd4, K_CLOSE, 0,  8};

        apply_reset();
        for (int s = 0; s < 3; s++) begin
            check_output("rst_trig", int'(trig[s]), 0);
            check_output("rst_last", int'(last[s]), 0);
            check_output("rst_chg",  int'(chg[s]),  0);
            check_output("rst_qw",   int'(qw[s]),   0);
            check_output("rst_rd",   get_rd(s),     0);
        end

        for (int v = 0; v < 12; v++) begin
            apply_stimulus(vecs[v].sel, vecs[v].wr, vecs[v].tmo);
            expect_request(vecs[v].sel, 200, vecs[v].kind, vecs[v].qwn, $sformatf("vec%0d", v));
            ack_request(vecs[v].sel, vecs[v].kind, 0, vecs[v].rd_after, $sformatf("vec%0d", v));
        end

        // partial flush rises timeout_value+1 cycles after leaving reset
        apply_reset();
        apply_stimulus(0, 15'd3, 16'd8);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_output($sformatf("tmo_edge%0d", c), int'(last[0]), (c == 9) ? 1 : 0);
        end
        check_output("tmo_qw", int'(qw[0]), 3);
        ack_request(0, K_LAST, 0, 3, "tmo");

        apply_reset();
        apply_stimulus(0, 15'd3, 16'd0);
        wait_request(0, 1000, k);
        check_output("tmo0_quiet", k, K_NONE);

        // page gating, hold across gating drop and a stray close ack
        apply_reset();
        hpa[0] = 1'b0;
        apply_stimulus(0, 15'h20, 16'd0);
        wait_request(0, 50, k);
        check_output("gate_block", k, K_NONE);
        hpa[0] = 1'b1;
        expect_request(0, 10, K_FULL, 16, "gate_open");
        hpa[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_output("gate_hold", cur_kind(0), K_FULL);
        cack[0] = 1'b1;
        @(negedge clk);
        cack[0] = 1'b0;
        repeat (2) @(negedge clk);
        check_output("stray_kind", cur_kind(0), K_FULL);
        check_output("stray_rd", get_rd(0), 0);
        ack_request(0, K_FULL, 0, 'h10, "gate_ack");
        wait_request(0, 20, k);
        check_output("gate_block2", k, K_NONE);
        hpa[0] = 1'b1;
        expect_request(0, 10, K_FULL, 16, "gate_reopen");
        #2 reset_n = 1'b0;
        #1;
        check_output("arst_trig", int'(trig[0]), 0);
        check_output("arst_last", int'(last[0]), 0);
        check_output("arst_chg",  int'(chg[0]),  0);
        check_output("arst_qw",   int'(qw[0]),   0);
        check_output("arst_rd",   get_rd(0),     0);

        // randomized traffic on instance 2, one input change per round
        apply_reset();
        rand_hpa[2] = 1'b1;
        m_rd = 0; m_off = M_HDR; m_wr = 0; m_tmo = 0;
        for (int r = 0; r < 50 && errors <= 20; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       m_tmo = 0;
                    1:       m_tmo = 2;
                    default: m_tmo = 5;
                endcase
                tmo[2] = 16'(m_tmo);
            end else begin
                outst = (m_wr - m_rd) & 63;
                n     = $urandom_range(0, 63 - outst);
                m_wr  = (m_wr + n) & 63;
                set_wr(2, 15'(m_wr));
            end
            for (int t = 0; t < 8; t++) begin
                model_next((m_wr - m_rd) & 63, m_off, m_tmo, ek, eq);
                if (ek == K_NONE) break;
                expect_request(2, 100, ek, eq, "rnd");
                case (ek)
                    K_FULL:  begin m_rd = (m_rd + M_MAX) & 63; m_off = m_off + M_MAX; end
                    K_LAST:  begin m_rd = (m_rd + eq) & 63;    m_off = M_HDR; end
                    default:       m_off = M_HDR;
                endcase
                ack_request(2, ek, $urandom_range(0, 3), m_rd, "rnd");
            end
            rand_hpa[2] = 1'b0;
            hpa[2]      = 1'b1;
            wait_request(2, m_tmo + 30, k);
            check_output("rnd_quiet", k, K_NONE);
            rand_hpa[2] = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
